// File: rtl/ringosc_meas_ctrl.sv
// Ring-oscillator frequency measurement controller: settle, gated edge count, result hold.
// Optional macro RINGOSC_CONTINUOUS_EN re-arms the gate window back-to-back after each result.
module ringosc_meas_ctrl #(
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       gate_sel,
    input  logic             osc_in,
    output logic             osc_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result,
    output logic             overflow
);

    // Timer must hold SETTLE_CYC-1 and the 2^13 window length before the -1.
    localparam int TMR_W = ($clog2(SETTLE_CYC) > 14) ? $clog2(SETTLE_CYC) : 14;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_GATE   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         gsel_q, gsel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               sync1_q, sync2_q, hist_q;

    logic               rise;
    logic               cnt_sat;
    logic               abort_req;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_inc;
    logic [TMR_W-1:0]   gate_last;
    logic [TMR_W-1:0]   settle_last;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= osc_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    always_comb begin
        rise        = sync2_q & ~hist_q;
        cnt_sat     = &cnt_q;
        cnt_inc     = cnt_q + CNT_W'(rise & ~cnt_sat);
        ovf_inc     = ovf_q | (rise & cnt_sat);
        abort_req   = abort | ~ena;
        gate_last   = (TMR_W'(64) << gsel_q) - TMR_W'(1);
        settle_last = TMR_W'(SETTLE_CYC - 1);
    end

    // State and datapath register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            gsel_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            gsel_q     <= gsel_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state logic; abort is tested before window completion so it wins a tie.
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        gsel_d     = gsel_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        case (state_q)
            S_IDLE: begin
                if (start && ena && !abort) begin
                    state_d = S_SETTLE;
                    tmr_d   = '0;
                    gsel_d  = gate_sel;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_SETTLE: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else if (tmr_q == settle_last) begin
                    state_d = S_GATE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_GATE: begin
                if (abort_req) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    ovf_d = ovf_inc;
                    if (tmr_q == gate_last) begin
                        state_d    = S_DONE;
                        result_d   = cnt_inc;
                        overflow_d = ovf_inc;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
            end
            S_DONE: begin
`ifdef RINGOSC_CONTINUOUS_EN
                if (ena && !abort) begin
                    state_d = S_GATE;
                    tmr_d   = '0;
                    gsel_d  = gate_sel;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        osc_en = 1'b0;
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        case (state_q)
            S_SETTLE: osc_en = 1'b1;
            S_GATE:   osc_en = 1'b1;
`ifdef RINGOSC_CONTINUOUS_EN
            // Keep the oscillator running across the result cycle when re-arming.
            S_DONE:   osc_en = ena & ~abort;
`endif
            default:  osc_en = 1'b0;
        endcase
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Self-checking bench for ringosc_meas_ctrl: timestamp-based reference model plus directed literals.
module tb_ringosc_meas_ctrl;

    localparam int S    = 16;
    localparam int NMAX = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] gate_sel = 3'd0;
    logic       osc_a = 1'b0;
    logic       osc_b = 1'b0;

    logic        osc_en_a, busy_a, done_a, ovf_a;
    logic [15:0] result_a;
    logic        osc_en_b, busy_b, done_b, ovf_b;
    logic [3:0]  result_b;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    ringosc_meas_ctrl #(.CNT_W(16), .SETTLE_CYC(S)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .gate_sel(gate_sel), .osc_in(osc_a), .osc_en(osc_en_a), .busy(busy_a),
        .done(done_a), .result(result_a), .overflow(ovf_a)
    );

    ringosc_meas_ctrl #(.CNT_W(4), .SETTLE_CYC(S)) dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .abort(abort),
        .gate_sel(gate_sel), .osc_in(osc_b), .osc_en(osc_en_b), .busy(busy_b),
        .done(done_b), .result(result_b), .overflow(ovf_b)
    );

    always #5 clk = ~clk;

    // Oscillator stimulus: period 8 clk on A, period 4 clk on B, changed away from the sampling edge.
    int cyc = 0;
    always @(negedge clk) begin
        cyc   = cyc + 1;
        osc_a = ((cyc / 4) % 2) == 1;
        osc_b = ((cyc / 2) % 2) == 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        chk_cnt = chk_cnt + 1;
        if (act == exp) pass_cnt = pass_cnt + 1;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a measurement is described by the edge it was accepted on (m_s)
    // and its window length (m_w); GATE spans edges m_s+S .. m_s+S+m_w-1, DONE follows.
    int n = 0;
    bit oa_s [NMAX];
    bit ob_s [NMAX];
    bit m_active = 1'b0;
    int m_s = 0;
    int m_w = 64;
    int m_res_a = 0, m_res_b = 0;
    bit m_ovf_a = 1'b0, m_ovf_b = 1'b0;

    // Rising edges of the osc sample stream as seen two flops late, over the gate window.
    function automatic int win_count(input bit use_b, input int g, input int w);
        int c = 0;
        for (int k = g; k < g + w; k++) begin
            if (use_b) c += (ob_s[k-1] && !ob_s[k-2]) ? 1 : 0;
            else       c += (oa_s[k-1] && !oa_s[k-2]) ? 1 : 0;
        end
        return c;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_res_a  = 0;
        m_res_b  = 0;
        m_ovf_a  = 1'b0;
        m_ovf_b  = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        int de, ca, cb;
        n = n + 1;
        if (n < NMAX) begin
            oa_s[n] = osc_a;
            ob_s[n] = osc_b;
        end
        if (!rst_n) begin
            model_reset();
        end else if (m_active) begin
            de = m_s + S + m_w;
            if (n - 1 < de) begin
                if (abort || !ena) begin
                    m_active = 1'b0;
                end else if (n == de) begin
                    ca = win_count(1'b0, m_s + S, m_w);
                    cb = win_count(1'b1, m_s + S, m_w);
                    m_res_a = (ca > 65535) ? 65535 : ca;
                    m_ovf_a = (ca > 65535);
                    m_res_b = (cb > 15) ? 15 : cb;
                    m_ovf_b = (cb > 15);
                end
            end else begin
`ifdef RINGOSC_CONTINUOUS_EN
                if (ena && !abort) begin
                    m_s = n - S;
                    m_w = 64 << gate_sel;
                end else begin
                    m_active = 1'b0;
                end
`else
                m_active = 1'b0;
`endif
            end
        end else if (start && ena && !abort) begin
            m_active = 1'b1;
            m_s      = n;
            m_w      = 64 << gate_sel;
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        int de;
        bit e_busy, e_done, e_osc;
        #1;
        if (rst_n) begin
            de     = m_s + S + m_w;
            e_busy = m_active && (n >= m_s) && (n <= de);
            e_done = m_active && (n == de);
            e_osc  = m_active && (n >= m_s) && (n < de);
`ifdef RINGOSC_CONTINUOUS_EN
            if (e_done && ena && !abort) e_osc = 1'b1;
`endif
            chk("busy_a",   int'(busy_a),   int'(e_busy));
            chk("done_a",   int'(done_a),   int'(e_done));
            chk("osc_en_a", int'(osc_en_a), int'(e_osc));
            chk("result_a", int'(result_a), m_res_a);
            chk("ovf_a",    int'(ovf_a),    int'(m_ovf_a));
            chk("busy_b",   int'(busy_b),   int'(e_busy));
            chk("done_b",   int'(done_b),   int'(e_done));
            chk("osc_en_b", int'(osc_en_b), int'(e_osc));
            chk("result_b", int'(result_b), m_res_b);
            chk("ovf_b",    int'(ovf_b),    int'(m_ovf_b));
        end
    end

    // One measurement from the current negedge; releases DONE with a one-cycle abort.
    task automatic run_meas(input logic [2:0] gs, input int exp_lat, input int exp_a,
                            input int exp_b, input int exp_ovb);
        int lat = 0;
        start    = 1'b1;
        gate_sel = gs;
        while (1) begin
            @(negedge clk);
            start = 1'b0;
            lat   = lat + 1;
            if (done_a || lat >= 2000) break;
        end
        if (!done_a) begin
            chk_cnt = chk_cnt + 1;
            $display("FAIL done_timeout: no done within %0d cycles, expected at %0d", lat, exp_lat);
        end
        chk("latency",      lat,            exp_lat);
        chk("lit_result_a", int'(result_a), exp_a);
        chk("lit_ovf_a",    int'(ovf_a),    0);
        chk("lit_result_b", int'(result_b), exp_b);
        chk("lit_ovf_b",    int'(ovf_b),    exp_ovb);
        $display("meas gsel=%0d lat=%0d result_a=%0d ovf_a=%0d result_b=%0d ovf_b=%0d",
                 gs, lat, result_a, ovf_a, result_b, ovf_b);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        int ndone;
        ena = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_osc_en", int'(osc_en_a), 0);
        chk("rst_busy",   int'(busy_a),   0);
        chk("rst_done",   int'(done_a),   0);
        chk("rst_result", int'(result_a), 0);
        chk("rst_ovf",    int'(ovf_a),    0);
        rst_n = 1'b1;
        @(negedge clk);

        // Period 8 over 64 cycles -> 8 edges; B sees 16 edges and saturates at 15.
        run_meas(3'd0, 1 + S + 64, 8, 15, 1);
        // 512-cycle window: A counts 64, B saturates.
        run_meas(3'd3, 1 + S + 512, 64, 15, 1);
        // 128-cycle window: A counts 16.
        run_meas(3'd1, 1 + S + 128, 16, 15, 1);

        // Abort during GATE cycle 20.
        start = 1'b1; gate_sel = 3'd0;
        for (int i = 1; i <= 37; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_osc_en", int'(osc_en_a), 0);
        chk("abort_busy",   int'(busy_a),   0);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_a) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_result_kept", int'(result_a), 16);
        $display("abort in GATE: result_a=%0d dones=%0d", result_a, ndone);

        // ena low during SETTLE aborts as well.
        start = 1'b1; gate_sel = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        ena = 1'b0;
        @(negedge clk);
        ena = 1'b1;
        chk("ena_abort_busy", int'(busy_a), 0);
        repeat (90) @(negedge clk);
        chk("ena_abort_result", int'(result_a), 16);
        $display("ena abort in SETTLE: result_a=%0d", result_a);

        // Second start with a different gate_sel during GATE is ignored.
        start = 1'b1; gate_sel = 3'd0;
        ndone = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            start    = (i == 30);
            gate_sel = (i == 30) ? 3'd2 : 3'd0;
            if (done_a) ndone++;
            abort = done_a;
        end
        abort = 1'b0;
        chk("restart_one_done", ndone, 1);
        chk("restart_result",   int'(result_a), 8);
        $display("start during GATE: dones=%0d result_a=%0d", ndone, result_a);

        // Reset during GATE clears all outputs at once; start right after release.
        start = 1'b1; gate_sel = 3'd0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mrst_osc_en_a", int'(osc_en_a), 0);
        chk("mrst_busy_a",   int'(busy_a),   0);
        chk("mrst_done_a",   int'(done_a),   0);
        chk("mrst_result_a", int'(result_a), 0);
        chk("mrst_ovf_a",    int'(ovf_a),    0);
        chk("mrst_result_b", int'(result_b), 0);
        chk("mrst_ovf_b",    int'(ovf_b),    0);
        $display("reset in GATE: busy_a=%0d result_a=%0d", busy_a, result_a);
        @(negedge clk);
        rst_n = 1'b1;
        run_meas(3'd0, 1 + S + 64, 8, 15, 1);

`ifdef RINGOSC_CONTINUOUS_EN
        begin
            int gap;
            start = 1'b1; gate_sel = 3'd0;
            gap = 0;
            while (1) begin
                @(negedge clk);
                start = 1'b0;
                gap++;
                if (done_a || gap >= 500) break;
            end
            chk("cont_first_lat", gap, 1 + S + 64);
            for (int r = 0; r < 2; r++) begin
                gap = 0;
                while (1) begin
                    @(negedge clk);
                    gap++;
                    chk("cont_osc_en", int'(osc_en_a), 1);
                    if (done_a || gap >= 500) break;
                end
                chk("cont_gap",    gap,            65);
                chk("cont_result", int'(result_a), 8);
                $display("continuous: gap=%0d result_a=%0d", gap, result_a);
            end
            ena = 1'b0;
            @(negedge clk);
            ena = 1'b1;
            chk("cont_stop_busy", int'(busy_a), 0);
        end
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
